// File: rtl/dbus_uncached_bridge.sv
// Uncached data-bus bridge: accepts one memory-stage dbus request, folds the
// kseg0/kseg1 virtual address to physical, issues it as a single-beat cbus
// transaction and returns load data / store completion. One transaction at a time.
module dbus_uncached_bridge #(
    parameter bit PADDR_MAP = 1'b1,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dreq_valid,
    input  logic [31:0]       dreq_addr,
    input  logic [2:0]        dreq_size,
    input  logic [3:0]        dreq_strobe,
    input  logic [DATA_W-1:0] dreq_data,
    output logic              dresp_addr_ok,
    output logic              dresp_data_ok,
    output logic [DATA_W-1:0] dresp_data,
    output logic              creq_valid,
    output logic              creq_is_write,
    output logic [2:0]        creq_size,
    output logic [31:0]       creq_addr,
    output logic [3:0]        creq_strobe,
    output logic [DATA_W-1:0] creq_data,
    output logic [3:0]        creq_len,
    input  logic              cresp_ready,
    input  logic              cresp_last,
    input  logic [DATA_W-1:0] cresp_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [31:0]       addr_q;
    logic [2:0]        size_q;
    logic [3:0]        strobe_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rbuf_q;
    logic              is_write_q;

    logic [31:0]       paddr;
    logic              accept;
    logic              beat_done;

    // Fold kseg0/kseg1 onto the low 512 MiB of physical space; everything else passes through.
    always_comb begin
        paddr = dreq_addr;
        if (PADDR_MAP && ((dreq_addr[31:29] == 3'b100) || (dreq_addr[31:29] == 3'b101))) begin
            paddr = {3'b000, dreq_addr[28:0]};
        end
    end

    // Next-state and handshake decode; addr_ok is only ever raised while idle.
    always_comb begin
        state_next    = state;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        creq_valid    = 1'b0;
        accept        = 1'b0;
        beat_done     = 1'b0;
        case (state)
            IDLE: begin
                dresp_addr_ok = dreq_valid;
                accept        = dreq_valid;
                if (dreq_valid) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                creq_valid = 1'b1;
                if (cresp_ready && cresp_last) begin
                    beat_done  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                dresp_data_ok = 1'b1;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset abandons any in-flight cbus beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request latch: captured at accept so the cbus side is stable for the whole REQ state.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= 32'd0;
            size_q     <= 3'd0;
            strobe_q   <= 4'd0;
            data_q     <= '0;
            is_write_q <= 1'b0;
        end else if (accept) begin
            addr_q     <= paddr;
            size_q     <= dreq_size;
            strobe_q   <= dreq_strobe;
            data_q     <= dreq_data;
            is_write_q <= |dreq_strobe;
        end
    end

    // Read buffer: only loads overwrite it, so after a store it still shows the last load word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rbuf_q <= '0;
        end else if (beat_done && !is_write_q) begin
            rbuf_q <= cresp_data;
        end
    end

    assign creq_is_write = is_write_q;
    assign creq_size     = size_q;
    assign creq_addr     = addr_q;
    assign creq_strobe   = strobe_q;
    assign creq_data     = data_q;
    assign creq_len      = 4'd0;
    assign dresp_data    = rbuf_q;

endmodule

// File: tb/tb_dbus_uncached_bridge.sv
// Self-checking bench for dbus_uncached_bridge. Two instances share all inputs:
// one folds kseg0/kseg1 addresses, the other passes addresses through unchanged.
// Expected cbus requests and response words are queued at accept and compared
// when the bridge presents them.
module tb_dbus_uncached_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        cresp_ready;
    logic        cresp_last;
    logic [31:0] cresp_data;

    logic        dresp_addr_ok, dresp_data_ok;
    logic [31:0] dresp_data;
    logic        creq_valid, creq_is_write;
    logic [2:0]  creq_size;
    logic [31:0] creq_addr;
    logic [3:0]  creq_strobe;
    logic [31:0] creq_data;
    logic [3:0]  creq_len;

    logic        pt_addr_ok, pt_data_ok;
    logic [31:0] pt_dresp_data;
    logic        pt_creq_valid, pt_is_write;
    logic [2:0]  pt_size;
    logic [31:0] pt_addr;
    logic [3:0]  pt_strobe;
    logic [31:0] pt_data;
    logic [3:0]  pt_len;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] addr_pt;
        logic        is_write;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [31:0] rdata;
    } exp_t;

    exp_t        req_q[$];
    logic [31:0] resp_q[$];
    logic [31:0] last_load;

    always #5 clk = ~clk;

    dbus_uncached_bridge #(.PADDR_MAP(1'b1), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_size(creq_size),
        .creq_addr(creq_addr), .creq_strobe(creq_strobe), .creq_data(creq_data), .creq_len(creq_len),
        .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data)
    );

    dbus_uncached_bridge #(.PADDR_MAP(1'b0), .DATA_W(32)) dut_pt (
        .clk(clk), .reset(reset),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(pt_addr_ok), .dresp_data_ok(pt_data_ok), .dresp_data(pt_dresp_data),
        .creq_valid(pt_creq_valid), .creq_is_write(pt_is_write), .creq_size(pt_size),
        .creq_addr(pt_addr), .creq_strobe(pt_strobe), .creq_data(pt_data), .creq_len(pt_len),
        .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data)
    );

    // Reference translation: kseg0/kseg1 lose their top three bits.
    function automatic logic [31:0] xlate(input logic [31:0] va);
        if ((va[31:29] == 3'b100) || (va[31:29] == 3'b101)) return {3'b000, va[28:0]};
        return va;
    endfunction

    // Present a request in an idle cycle, expect same-cycle addr_ok and queue the expectations.
    task automatic accept_req(input logic [31:0] addr, input logic [2:0] size,
                              input logic [3:0] strobe, input logic [31:0] data,
                              input logic [31:0] rdata);
        exp_t e;
        @(negedge clk);
        dreq_valid  = 1'b1;
        dreq_addr   = addr;
        dreq_size   = size;
        dreq_strobe = strobe;
        dreq_data   = data;
        #1;
        checks++;
        if (dresp_addr_ok !== 1'b1 || pt_addr_ok !== 1'b1) begin
            failures++;
            $display("[TB] FAIL accept_addr_ok addr=%h got=%b/%b exp=1/1", addr, dresp_addr_ok, pt_addr_ok);
        end
        e.addr     = xlate(addr);
        e.addr_pt  = addr;
        e.is_write = |strobe;
        e.size     = size;
        e.strobe   = strobe;
        e.data     = data;
        e.rdata    = rdata;
        req_q.push_back(e);
        if (|strobe) begin
            resp_q.push_back(last_load);
        end else begin
            resp_q.push_back(rdata);
            last_load = rdata;
        end
    endtask

    // Hold the REQ state for wait_cycles, checking the cbus side is stable, then complete the beat
    // and check the single RESP cycle. Optionally drops dreq_valid and injects a beat without last.
    task automatic serve(input int wait_cycles, input bit drop_valid, input bit stray_beat);
        exp_t        e;
        logic [31:0] exp_word;
        if (req_q.size() == 0 || resp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty got=%0d exp=1", req_q.size());
            return;
        end
        e = req_q.pop_front();
        for (int i = 0; i <= wait_cycles; i++) begin
            @(negedge clk);
            if (i == 0 && drop_valid) dreq_valid = 1'b0;
            #1;
            checks++;
            if (creq_valid !== 1'b1 || creq_addr !== e.addr || creq_is_write !== e.is_write ||
                creq_size !== e.size || creq_strobe !== e.strobe || creq_data !== e.data ||
                creq_len !== 4'd0) begin
                failures++;
                $display("[TB] FAIL creq_fields cyc=%0d got v=%b a=%h w=%b s=%0d st=%b d=%h l=%0d exp v=1 a=%h w=%b s=%0d st=%b d=%h l=0",
                         i, creq_valid, creq_addr, creq_is_write, creq_size, creq_strobe, creq_data, creq_len,
                         e.addr, e.is_write, e.size, e.strobe, e.data);
            end
            checks++;
            if (pt_creq_valid !== 1'b1 || pt_addr !== e.addr_pt) begin
                failures++;
                $display("[TB] FAIL passthrough_addr got v=%b a=%h exp v=1 a=%h", pt_creq_valid, pt_addr, e.addr_pt);
            end
            checks++;
            if (dresp_addr_ok !== 1'b0 || dresp_data_ok !== 1'b0) begin
                failures++;
                $display("[TB] FAIL req_handshake got addr_ok=%b data_ok=%b exp 0/0", dresp_addr_ok, dresp_data_ok);
            end
            if (i == wait_cycles) begin
                cresp_ready = 1'b1;
                cresp_last  = 1'b1;
                cresp_data  = e.rdata;
            end else if (stray_beat && i == 0) begin
                cresp_ready = 1'b1;
                cresp_last  = 1'b0;
                cresp_data  = ~e.rdata;
            end else begin
                cresp_ready = 1'b0;
                cresp_last  = 1'b0;
                cresp_data  = $urandom;
            end
        end
        exp_word = resp_q.pop_front();
        @(negedge clk);
        cresp_ready = 1'b0;
        cresp_last  = 1'b0;
        cresp_data  = $urandom;
        #1;
        checks++;
        if (dresp_data_ok !== 1'b1 || dresp_data !== exp_word) begin
            failures++;
            $display("[TB] FAIL resp_data got ok=%b data=%h exp ok=1 data=%h", dresp_data_ok, dresp_data, exp_word);
        end
        checks++;
        if (creq_valid !== 1'b0 || dresp_addr_ok !== 1'b0) begin
            failures++;
            $display("[TB] FAIL resp_quiet got creq_valid=%b addr_ok=%b exp 0/0", creq_valid, dresp_addr_ok);
        end
    endtask

    // Idle cycle after a response: no second data_ok and nothing on the cbus.
    task automatic expect_idle(input string tag);
        @(negedge clk);
        #1;
        checks++;
        if (dresp_data_ok !== 1'b0 || creq_valid !== 1'b0 || dresp_addr_ok !== dreq_valid) begin
            failures++;
            $display("[TB] FAIL idle_%s got data_ok=%b creq_valid=%b addr_ok=%b exp 0/0/%b",
                     tag, dresp_data_ok, creq_valid, dresp_addr_ok, dreq_valid);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        dreq_valid  = 1'b0;
        dreq_addr   = 32'h0;
        dreq_size   = 3'd0;
        dreq_strobe = 4'd0;
        dreq_data   = 32'h0;
        cresp_ready = 1'b0;
        cresp_last  = 1'b0;
        cresp_data  = 32'h0;
        last_load   = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (dresp_addr_ok !== 1'b0 || dresp_data_ok !== 1'b0 || dresp_data !== 32'h0 ||
            creq_valid !== 1'b0 || creq_is_write !== 1'b0 || creq_size !== 3'd0 ||
            creq_addr !== 32'h0 || creq_strobe !== 4'h0 || creq_data !== 32'h0 || creq_len !== 4'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got ok=%b/%b d=%h v=%b w=%b s=%0d a=%h st=%b cd=%h l=%0d exp all 0",
                     dresp_addr_ok, dresp_data_ok, dresp_data, creq_valid, creq_is_write, creq_size,
                     creq_addr, creq_strobe, creq_data, creq_len);
        end
    endtask

    task automatic test_load();
        accept_req(32'h8000_0010, 3'd2, 4'b0000, 32'h0, 32'hDEAD_BEEF);
        serve(1, 1'b1, 1'b0);
        expect_idle("load");
    endtask

    task automatic test_min_latency();
        accept_req(32'h0000_1234, 3'd1, 4'b0000, 32'h0, 32'h1357_9BDF);
        serve(0, 1'b1, 1'b0);
        expect_idle("minlat");
    endtask

    task automatic test_store();
        accept_req(32'hA000_0003, 3'd0, 4'b1000, 32'h5500_0000, 32'hFFFF_FFFF);
        serve(3, 1'b1, 1'b1);
        expect_idle("store");
    endtask

    task automatic test_back_to_back();
        accept_req(32'h8000_0100, 3'd2, 4'b0000, 32'h0, 32'hCAFE_0001);
        @(posedge clk);
        #1;
        dreq_addr   = 32'h8000_0200;
        dreq_strobe = 4'b1111;
        dreq_data   = 32'h0BAD_F00D;
        serve(2, 1'b0, 1'b0);
        accept_req(32'h8000_0200, 3'd2, 4'b1111, 32'h0BAD_F00D, 32'h0);
        serve(1, 1'b1, 1'b0);
        expect_idle("b2b");
    endtask

    task automatic test_squash();
        accept_req(32'h9000_0040, 3'd2, 4'b0000, 32'h0, 32'h2468_ACE0);
        serve(2, 1'b1, 1'b0);
        expect_idle("squash0");
        expect_idle("squash1");
    endtask

    task automatic test_reset_mid();
        accept_req(32'hA000_0080, 3'd2, 4'b0011, 32'h0000_1111, 32'h0);
        @(negedge clk);
        dreq_valid = 1'b0;
        #1;
        checks++;
        if (creq_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_inreq got creq_valid=%b exp 1", creq_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (creq_valid !== 1'b0 || dresp_data_ok !== 1'b0 || dresp_addr_ok !== 1'b0 ||
            dresp_data !== 32'h0 || creq_addr !== 32'h0 || creq_strobe !== 4'h0 ||
            creq_data !== 32'h0 || creq_is_write !== 1'b0 || creq_size !== 3'd0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs got v=%b ok=%b/%b d=%h a=%h st=%b cd=%h w=%b s=%0d exp all 0",
                     creq_valid, dresp_addr_ok, dresp_data_ok, dresp_data, creq_addr, creq_strobe,
                     creq_data, creq_is_write, creq_size);
        end
        req_q.delete();
        resp_q.delete();
        last_load = 32'h0;
        expect_idle("midreset");
        accept_req(32'h8000_0010, 3'd2, 4'b1111, 32'h7777_8888, 32'h0);
        serve(0, 1'b1, 1'b0);
        expect_idle("afterreset");
    endtask

    task automatic test_passthrough();
        accept_req(32'hBFC0_0004, 3'd2, 4'b0000, 32'h0, 32'h3C08_BFC0);
        serve(1, 1'b1, 1'b0);
        accept_req(32'h0040_0000, 3'd2, 4'b0000, 32'h0, 32'h0000_0042);
        serve(0, 1'b1, 1'b0);
        expect_idle("passthrough");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_load();
        test_min_latency();
        test_store();
        test_load();
        test_back_to_back();
        test_squash();
        test_reset_mid();
        test_passthrough();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
